// File: rtl/serial_add32_ctrl.sv
// serial_add32_ctrl: 32-bit add/subtract computed one byte per clock
// through a single shared 8-bit ripple-carry slice.

module serial_add32_slice (
    input  logic       cin,
    input  logic [7:0] a8,
    input  logic [7:0] b8,
    output logic [7:0] s8,
    output logic       cout,
    output logic       overflow
);
    logic [8:0] w_c;

    // NOTE: every bit of s8 and w_c is assigned on every pass, so no latch is inferred.
    always_comb begin
        w_c[0] = cin;
        s8     = 8'h00;
        for (int i = 0; i < 8; i++) begin
            s8[i]    = a8[i] ^ b8[i] ^ w_c[i];
            w_c[i+1] = (a8[i] & b8[i]) | (w_c[i] & (a8[i] ^ b8[i]));
        end
    end

    assign cout     = w_c[8];
    assign overflow = w_c[8] ^ w_c[7];
endmodule

module serial_add32_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sub,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] s,
    output logic        cout,
    output logic        overflow,
    output logic        zero
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  r_idx;
    logic        r_carry;
    logic        r_sub;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_s;
    logic        r_cout;
    logic        r_ovf;
    logic        r_zero;

    logic [7:0]  w_a8;
    logic [7:0]  w_b8;
    logic [7:0]  w_s8;
    logic        w_cout;
    logic        w_ovf;
    logic [31:0] w_s_full;

    // Subtraction is a + ~b + 1: the byte of b is inverted and the carry seeded with sub.
    always_comb begin
        w_a8     = r_a[8*r_idx +: 8];
        w_b8     = r_b[8*r_idx +: 8] ^ {8{r_sub}};
        w_s_full = {w_s8, r_s[23:0]};
    end

    serial_add32_slice u_slice (
        .cin      (r_carry),
        .a8       (w_a8),
        .b8       (w_b8),
        .s8       (w_s8),
        .cout     (w_cout),
        .overflow (w_ovf)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= 2'd0;
            r_carry <= 1'b0;
            r_sub   <= 1'b0;
            r_a     <= 32'h0;
            r_b     <= 32'h0;
            r_s     <= 32'h0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_sub   <= sub;
                        r_idx   <= 2'd0;
                        r_carry <= sub;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_s[8*r_idx +: 8] <= w_s8;
                    r_carry           <= w_cout;
                    r_idx             <= r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        r_cout  <= w_cout;
                        r_ovf   <= w_ovf;
                        r_zero  <= (w_s_full == 32'h0);
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = (r_state == ST_RUN);
    assign done     = (r_state == ST_DONE);
    assign s        = r_s;
    assign cout     = r_cout;
    assign overflow = r_ovf;
    assign zero     = r_zero;
endmodule
